// File: rtl/gon_collector.sv
// gon_collector: global output network gathering PE psums into a 2-entry FIFO toward SRAM; GON_MULTIMATCH_ERR_EN adds a sticky multi-match flag.
`ifndef NUMS_PE_ROW
`define NUMS_PE_ROW 6
`endif
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif
`ifndef XID_BITS
`define XID_BITS 5
`endif
`ifndef YID_BITS
`define YID_BITS 4
`endif

module gon_collector #(
    parameter int NUMS_PE_ROW = `NUMS_PE_ROW,
    parameter int NUMS_PE_COL = `NUMS_PE_COL,
    parameter int DATA_BITS   = `DATA_BITS,
    parameter int XID_BITS    = `XID_BITS,
    parameter int YID_BITS    = `YID_BITS,
    localparam int NPE        = NUMS_PE_ROW * NUMS_PE_COL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XID_BITS-1:0]      tag_X,
    input  logic [YID_BITS-1:0]      tag_Y,
    input  logic                     set_XID,
    input  logic [XID_BITS-1:0]      XID_scan_in,
    input  logic                     set_YID,
    input  logic [YID_BITS-1:0]      YID_scan_in,
    input  logic [NPE-1:0]           PE_valid,
    input  logic [NPE*DATA_BITS-1:0] PE_data,
    output logic [NPE-1:0]           PE_ready,
    output logic                     GON_valid,
    input  logic                     GON_ready,
`ifdef GON_MULTIMATCH_ERR_EN
    output logic                     multi_match_err,
`endif
    output logic [DATA_BITS-1:0]     GON_data
);
    localparam int SW = NPE > 1 ? $clog2(NPE) : 1;

    logic [XID_BITS-1:0]  xid [NPE];
    logic [YID_BITS-1:0]  yid [NUMS_PE_ROW];
    logic [NPE-1:0]       match;
    logic [SW-1:0]        sel;
    logic [DATA_BITS-1:0] mem [2];
    logic                 wr_ptr, rd_ptr, push, pop;
    logic [1:0]           count;

    // ID scan chains; both may shift in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPE; i++) xid[i] <= '0;
            for (int r = 0; r < NUMS_PE_ROW; r++) yid[r] <= '0;
        end else begin
            if (set_XID) begin
                xid[0] <= XID_scan_in;
                for (int i = 1; i < NPE; i++) xid[i] <= xid[i-1];
            end
            if (set_YID) begin
                yid[0] <= YID_scan_in;
                for (int r = 1; r < NUMS_PE_ROW; r++) yid[r] <= yid[r-1];
            end
        end
    end

    for (genvar g = 0; g < NPE; g++) begin : g_match
        assign match[g] = (yid[g / NUMS_PE_COL] == tag_Y) && (xid[g] == tag_X);
    end

    // lowest-index matching PE wins
    always_comb begin
        sel = '0;
        for (int i = NPE - 1; i >= 0; i--) if (match[i]) sel = SW'(i);
    end

    // one-hot accept; ready is gated by reset so it reads 0 while rst is low
    always_comb begin
        PE_ready = '0;
        PE_ready[sel] = rst && match[sel] && !count[1] && !set_XID && !set_YID;
    end

    assign push      = PE_valid[sel] && PE_ready[sel];
    assign pop       = GON_valid && GON_ready;
    assign GON_valid = count != 2'd0;
    assign GON_data  = mem[rd_ptr];

    // two-entry FIFO toward SRAM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= PE_data[DATA_BITS*sel +: DATA_BITS];
                wr_ptr      <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

`ifdef GON_MULTIMATCH_ERR_EN
    // sticky flag: several matches while a matched PE offers data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) multi_match_err <= 1'b0;
        else if (|(match & (match - NPE'(1))) && |(match & PE_valid)) multi_match_err <= 1'b1;
    end
`endif
endmodule
